// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch-entry layout and the helper that picks a 32-bit word out of a 64-bit beat.
package ifu_fetch_pkg;

    localparam logic [63:0] PC_INIT_DEFAULT = 64'h8000_0000;
    localparam int          INST_LEN        = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] select_word(input logic upper, input logic [63:0] data);
        return upper ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush and occupancy count; the head is a registered copy of
// the oldest entry, so a push becomes visible one cycle later and the head holds when empty.
module ifu_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A pop on an empty FIFO only takes effect alongside a push (the pushed word passes straight through).
    always_comb begin
        do_push     = push && !flush;
        do_pop      = pop && !flush && ((count_reg != '0) || push);
        rd_ptr_next = do_pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // Forward the incoming word when it becomes the new head; otherwise read ahead.
            if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
                head_reg <= push_data;
            end else if (count_next != '0) begin
                head_reg <= mem_reg[rd_ptr_next];
            end
        end
    end

    assign head  = head_reg;
    assign count = count_reg;

    assert property (@(posedge clk) disable iff (rst)
        (push && !pop && !flush) |-> (count_reg != FULL_CNT));

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues 64-bit reads, buffers {pc, inst} pairs, flushes on redirect.
// Optional misaligned-redirect trap is enabled by defining IFU_MISALIGN_TRAP_EN.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [63:0] PC_INIT = PC_INIT_DEFAULT,
    parameter int          DEPTH   = 4,
    parameter int          MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);
    localparam int IB_CW = $clog2(DEPTH) + 1;
    localparam int RQ_CW = $clog2(MAX_OUT) + 1;

    logic [63:0]      fetch_pc_reg;
    logic [RQ_CW-1:0] drop_reg;
    logic             trap_active;
    logic             req_fire, ib_push, ib_pop;
    fetch_entry_t     ib_push_data, ib_head;
    logic [IB_CW-1:0] ib_count;
    logic [63:0]      rq_head, resp_pc;
    logic [RQ_CW-1:0] rq_count;

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else if (redirect) begin
            misalign_reg <= |redirect_pc[1:0];
        end
    end

    assign trap_active    = misalign_reg;
    assign fetch_misalign = misalign_reg;
`else
    assign trap_active = 1'b0;
`endif

    // Reserve a buffer slot for every in-flight request so responses can always be accepted.
    assign mem_req_valid = !rst && !redirect && !trap_active
                         && (32'(rq_count) < MAX_OUT)
                         && ((32'(ib_count) + 32'(rq_count)) < DEPTH);
    assign mem_req_addr  = {fetch_pc_reg[63:3], 3'b000};
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response in the handshake cycle itself has no queue entry yet; its pc is the live fetch pc.
    assign resp_pc      = (rq_count == '0) ? fetch_pc_reg : rq_head;
    assign ib_push_data = '{pc: resp_pc, inst: select_word(resp_pc[2], mem_resp_data)};
    assign ib_push      = mem_resp_valid && (drop_reg == '0);
    assign ib_pop       = inst_valid && inst_ready;

    ifu_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(DEPTH)
    ) u_inst_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (ib_push),
        .push_data(ib_push_data),
        .pop      (ib_pop),
        .head     (ib_head),
        .count    (ib_count)
    );

    ifu_fifo #(
        .WIDTH(64),
        .DEPTH(MAX_OUT)
    ) u_req_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (req_fire),
        .push_data(fetch_pc_reg),
        .pop      (mem_resp_valid),
        .head     (rq_head),
        .count    (rq_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= PC_INIT;
            drop_reg     <= '0;
        end else if (redirect) begin
            fetch_pc_reg <= redirect_pc & ~64'h3;
            drop_reg     <= rq_count - RQ_CW'(mem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_reg <= fetch_pc_reg + 64'(INST_LEN);
            end
            if (mem_resp_valid && (drop_reg != '0)) begin
                drop_reg <= drop_reg - 1'b1;
            end
        end
    end

    assign inst_valid = (ib_count != '0) && !trap_active;
    assign inst       = ib_head.inst;
    assign inst_pc    = ib_head.pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch with a queue-based memory and an in-order PC scoreboard.
module tb_ifu_fetch;
    localparam logic [63:0] P_INIT  = 64'h8000_0000;
    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid, mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    always #5 clk = ~clk;

    ifu_fetch #(.PC_INIT(P_INIT), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
`ifdef IFU_MISALIGN_TRAP_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          rr_mode = 0;   // 0: ready always, 1: toggling, 2: random
    int          ir_mode = 0;   // 0: ready always, 1: never, 2: random
    int          issued, delivered;
    logic [63:0] exp_pc, req_pc, stall_addr;
    bit          stalled, prev_redir;
    bit          auto_redir, auto_hit;
    logic [63:0] auto_tgt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents: each 4-byte slot holds a pc-derived word.
    function automatic logic [31:0] word_of(input logic [63:0] pc);
        return pc[31:0] * 32'h9E37_79B9 + pc[63:32] + 32'h1234_5677;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        case ($urandom_range(0, 2))
            0:       t = P_INIT + 64'($urandom_range(0, 255)) * 64'd4 + 64'($urandom_range(0, 3));
            1:       t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
            default: t = {$urandom, $urandom};
        endcase
`ifdef IFU_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req_valid",  64'(mem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid),    64'd0);
        chk("rst_inst",       64'(inst),          64'd0);
        chk("rst_inst_pc",    inst_pc,            64'd0);
        pend.delete();
        exp_pc = P_INIT; req_pc = P_INIT;
        stalled = 0; prev_redir = 0; issued = 0; delivered = 0;
        rst = 1'b0;
    endtask

    // One clock: drive inputs after negedge, check outputs, then account for the coming posedge.
    task automatic cycle(input bit do_redir, input logic [63:0] tgt);
        @(negedge clk);
        cyc++;
        case (rr_mode)
            0:       mem_req_ready = 1'b1;
            1:       mem_req_ready = cyc[0];
            default: mem_req_ready = 1'($urandom_range(0, 1));
        endcase
        case (ir_mode)
            0:       inst_ready = 1'b1;
            1:       inst_ready = 1'b0;
            default: inst_ready = 1'($urandom_range(0, 1));
        endcase
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = {word_of(pend[0].addr + 64'd4), word_of(pend[0].addr)};
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = {$urandom, $urandom};
        end
        redirect    = do_redir;
        redirect_pc = tgt;
        if (auto_redir && mem_resp_valid && inst_valid && inst_ready && pend.size() == MAX_OUT) begin
            redirect    = 1'b1;
            redirect_pc = auto_tgt;
            auto_redir  = 0;
            auto_hit    = 1;
        end
        #1;
        if (prev_redir) chk("flush_empty", 64'(inst_valid), 64'd0);
        if (redirect) chk("req_off_on_redirect", 64'(mem_req_valid), 64'd0);
        if (stalled && !redirect) begin
            chk("req_hold_valid", 64'(mem_req_valid), 64'd1);
            chk("req_hold_addr",  mem_req_addr,       stall_addr);
        end
        if (mem_req_valid) chk("req_addr", mem_req_addr, {req_pc[63:3], 3'b000});
        if (inst_valid && inst_ready) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst",    64'(inst), 64'(word_of(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            delivered++;
        end
        if (mem_resp_valid) void'(pend.pop_front());
        if (mem_req_valid && mem_req_ready) begin
            pend.push_back('{addr: mem_req_addr, due: cyc + lat});
            req_pc = req_pc + 64'd4;
            issued++;
            chk("outstanding_le_max", 64'(pend.size() <= MAX_OUT), 64'd1);
        end
        stalled    = mem_req_valid && !mem_req_ready;
        stall_addr = mem_req_addr;
        if (redirect) begin
            exp_pc = redirect_pc & ~64'h3;
            req_pc = redirect_pc & ~64'h3;
        end
        prev_redir = redirect;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int d, n;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;
        auto_redir = 0; auto_hit = 0; auto_tgt = '0;

        // Free-running memory, 1-cycle latency: one instruction per cycle once warmed up.
        do_reset();
        rr_mode = 0; ir_mode = 0; lat = 1;
        repeat (10) cycle(0, '0);
        chk("first_deliveries", 64'(delivered >= 5), 64'd1);
        d = delivered;
        repeat (20) cycle(0, '0);
        chk("throughput", 64'(delivered - d), 64'd20);

        // Backpressure: buffer fills to exactly DEPTH and requests stop.
        do_reset();
        rr_mode = 0; ir_mode = 1; lat = 1;
        repeat (20) cycle(0, '0);
        chk("bp_inst_valid",  64'(inst_valid),    64'd1);
        chk("bp_req_stopped", 64'(mem_req_valid), 64'd0);
        chk("bp_issued",      64'(issued),        64'd4);
        chk("bp_no_pending",  64'(pend.size()),   64'd0);
        ir_mode = 0;
        repeat (8) cycle(0, '0);
        chk("bp_release", 64'(delivered >= 4), 64'd1);

        // Toggling request ready with 3-cycle response latency.
        do_reset();
        rr_mode = 1; ir_mode = 0; lat = 3;
        repeat (60) cycle(0, '0);
        chk("toggle_progress", 64'(delivered > 10), 64'd1);

        // Redirect with two requests outstanding, then a redirect that wraps past 2^64.
        do_reset();
        rr_mode = 0; ir_mode = 0; lat = 3;
        n = 0;
        while (pend.size() != MAX_OUT && n < 20) begin
            cycle(0, '0);
            n++;
        end
        chk("two_outstanding", 64'(pend.size()), 64'(MAX_OUT));
        cycle(1, 64'h8000_1000);
        d = delivered;
        repeat (15) cycle(0, '0);
        chk("redirect_progress", 64'(delivered - d >= 3), 64'd1);
        cycle(1, 64'hFFFF_FFFF_FFFF_FFF8);
        d = delivered;
        repeat (20) cycle(0, '0);
        chk("wrap_progress", 64'(delivered - d >= 4), 64'd1);

        // Redirect landing on a cycle with a response, a pop and a full request queue.
        do_reset();
        rr_mode = 0; ir_mode = 2; lat = 3;
        auto_tgt = 64'h8000_2000; auto_redir = 1; auto_hit = 0;
        n = 0;
        while (!auto_hit && n < 300) begin
            cycle(0, '0);
            n++;
        end
        auto_redir = 0;
        chk("coincident_redirect_hit", 64'(auto_hit), 64'd1);
        d = delivered;
        repeat (20) cycle(0, '0);
        chk("coincident_progress", 64'(delivered - d >= 2), 64'd1);

`ifdef IFU_MISALIGN_TRAP_EN
        do_reset();
        rr_mode = 0; ir_mode = 0; lat = 2;
        repeat (6) cycle(0, '0);
        cycle(1, 64'h8000_0002);
        repeat (8) begin
            cycle(0, '0);
            chk("misalign_flag",   64'(fetch_misalign), 64'd1);
            chk("misalign_no_req", 64'(mem_req_valid),  64'd0);
            chk("misalign_no_inst", 64'(inst_valid),    64'd0);
        end
        cycle(1, 64'h8000_0010);
        d = delivered;
        repeat (12) cycle(0, '0);
        chk("misalign_clear",  64'(fetch_misalign),     64'd0);
        chk("misalign_resume", 64'(delivered - d >= 3), 64'd1);
`endif

        // Random traffic with occasional redirects.
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            rr_mode = 2; ir_mode = 2; lat = $urandom_range(1, 3);
            d = delivered;
            repeat (300) begin
                if ($urandom_range(0, 24) == 0) cycle(1, rand_target());
                else cycle(0, '0);
            end
            chk("random_progress", 64'(delivered - d > 20), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
